// File: rtl/nese_clk_pkg.sv
// rtl/nese_clk_pkg.sv - shared opcodes, states and constants for the core-clock run scheduler
package nese_clk_pkg;

    localparam int CNT_W_DEF = 64;
    localparam int ARG_W_DEF = 32;
    localparam logic [CNT_W_DEF-1:0] FREE_VAL = '1;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_STEP  = 3'd1;
    localparam logic [2:0] OP_RUN   = 3'd2;
    localparam logic [2:0] OP_FREE  = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FREE = 2'd2,
        S_CLR  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/clk_sched_sat_add.sv
// rtl/clk_sched_sat_add.sv - saturating target adder; results never reach the free-run marker
module clk_sched_sat_add #(
    parameter int                CNT_W    = 64,
    parameter int                ARG_W    = 32,
    parameter logic [CNT_W-1:0]  FREE_VAL = {CNT_W{1'b1}}
) (
    input  logic [CNT_W-1:0] base,
    input  logic [ARG_W-1:0] addend,
    output logic [CNT_W-1:0] sum
);

    localparam logic [CNT_W:0] LIMIT = {1'b0, FREE_VAL} - {{CNT_W{1'b0}}, 1'b1};

    logic [CNT_W:0] wide;

    always_comb begin
        wide = {1'b0, base} + (CNT_W+1)'(addend);
        sum  = (wide >= LIMIT) ? LIMIT[CNT_W-1:0] : wide[CNT_W-1:0];
    end

endmodule

// File: rtl/clk_run_scheduler.sv
// rtl/clk_run_scheduler.sv - sequences the gated cycle counter for step/run/free-run/halt/clear
module clk_run_scheduler #(
    parameter int                CNT_W    = 64,
    parameter int                ARG_W    = 32,
    parameter logic [CNT_W-1:0]  FREE_VAL = {CNT_W{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [ARG_W-1:0] cmd_arg,
    input  logic             halt_req,
    input  logic             cnt_match,
    input  logic [CNT_W-1:0] cnt_value,
    output logic             gate_active,
    output logic             gate_reset,
    output logic [CNT_W-1:0] gate_trg,
    output logic             busy,
    output logic             done,
    output logic             cmd_err
);
    import nese_clk_pkg::*;

    sched_state_t     state, state_nx;
    logic [CNT_W-1:0] trg_q, trg_nx;
    logic [ARG_W-1:0] add_arg;
    logic [CNT_W-1:0] add_sum;
    logic             done_q, done_nx;
    logic             err_q, err_nx;

    assign add_arg = (cmd_op == OP_STEP) ? ARG_W'(1) : cmd_arg;

    clk_sched_sat_add #(
        .CNT_W    (CNT_W),
        .ARG_W    (ARG_W),
        .FREE_VAL (FREE_VAL)
    ) u_sat_add (
        .base   (trg_q),
        .addend (add_arg),
        .sum    (add_sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            trg_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            trg_q  <= trg_nx;
            done_q <= done_nx;
            err_q  <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        trg_nx   = trg_q;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_NOP: ;
                        OP_STEP: begin
                            trg_nx   = add_sum;
                            state_nx = S_RUN;
                        end
                        OP_RUN: begin
                            if (cmd_arg == '0) begin
                                done_nx = 1'b1;
                            end else begin
                                trg_nx   = add_sum;
                                state_nx = S_RUN;
                            end
                        end
                        OP_FREE:  state_nx = S_FREE;
                        OP_CLEAR: begin
                            trg_nx   = '0;
                            state_nx = S_CLR;
                        end
                        default:  err_nx = 1'b1;
                    endcase
                end
            end
            // A match wins over a coincident halt so the run ends as a normal completion.
            S_RUN: begin
                if (cnt_match) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end else if (halt_req) begin
                    trg_nx   = cnt_value;
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end
            end
            S_FREE: begin
                if (halt_req) begin
                    trg_nx   = cnt_value;
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end
            end
            S_CLR: begin
                state_nx = S_IDLE;
                done_nx  = 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are qualified by reset so an abort takes effect in the same cycle.
    assign cmd_ready   = !reset && (state == S_IDLE);
    assign gate_active = !reset && ((state == S_RUN) || (state == S_FREE));
    assign busy        = gate_active;
    assign gate_reset  = reset || (state == S_CLR);
    assign gate_trg    = reset ? '0 : ((state == S_FREE) ? FREE_VAL : trg_q);
    assign done        = !reset && done_q;
    assign cmd_err     = !reset && err_q;

endmodule

// File: tb/tb_clk_run_scheduler.sv
// tb/tb_clk_run_scheduler.sv - randomized self-checking bench with a behavioural counter and target model
module tb_clk_run_scheduler;
    import nese_clk_pkg::*;

    localparam logic [63:0] FV = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [31:0] cmd_arg = 32'd0;
    logic        halt_req = 1'b0;
    logic        cnt_match;
    logic [63:0] cnt_value;
    logic        gate_active;
    logic        gate_reset;
    logic [63:0] gate_trg;
    logic        busy;
    logic        done;
    logic        cmd_err;

    clk_run_scheduler #(.CNT_W(64), .ARG_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_arg     (cmd_arg),
        .halt_req    (halt_req),
        .cnt_match   (cnt_match),
        .cnt_value   (cnt_value),
        .gate_active (gate_active),
        .gate_reset  (gate_reset),
        .gate_trg    (gate_trg),
        .busy        (busy),
        .done        (done),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;

    // Gated counter: counts on negedge while enabled, clk_out pulses tallied per enabled phase.
    logic [63:0] cnt = 64'd0;
    logic        preload_en = 1'b0;
    logic [63:0] preload_val = 64'd0;
    int          pulses = 0;

    always @(negedge clk) begin
        if (gate_active) pulses <= pulses + 1;
        if (preload_en) cnt <= preload_val;
        else if (gate_reset) cnt <= 64'd0;
        else if (gate_active && cnt != gate_trg) cnt <= cnt + 64'd1;
    end
    assign cnt_value = cnt;
    assign cnt_match = (cnt == gate_trg);

    int n_checks = 0;
    int n_pass = 0;
    logic [63:0] exp_cnt = 64'd0;
    logic [63:0] exp_trg = 64'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] ref_sat(input logic [63:0] a, input logic [63:0] b);
        if (b >= (FV - 64'd1) - a) return FV - 64'd1;
        return a + b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] arg);
        int guard = 0;
        while (!cmd_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("cmd_ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_arg   = 32'd0;
    endtask

    task automatic observe(input int max_cyc, output int first_done, output int n_done, output int n_busy);
        first_done = -1;
        n_done = 0;
        n_busy = 0;
        for (int c = 0; c < max_cyc; c++) begin
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
            if (busy) n_busy++;
            if (first_done >= 0 && c >= first_done + 2) break;
            tick();
        end
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [31:0] arg);
        logic [63:0] new_trg;
        bit runs;
        int delta, lat, fd, nd, nb, p0;
        new_trg = exp_trg;
        runs = (op == OP_STEP) || (op == OP_RUN && arg != 0);
        if (op == OP_STEP) new_trg = ref_sat(exp_trg, 64'd1);
        else if (op == OP_RUN) new_trg = ref_sat(exp_trg, 64'(arg));
        else if (op == OP_CLEAR) new_trg = 64'd0;
        delta = int'(new_trg - exp_cnt);
        if (runs) lat = (delta == 0) ? 1 : delta;
        else if (op == OP_RUN) lat = 0;
        else if (op == OP_CLEAR) lat = 1;
        else lat = -1;
        p0 = pulses;
        issue(op, arg);
        check($sformatf("op%0d cmd_err", op), 64'(cmd_err), 64'(op >= 3'd5));
        observe((lat >= 0) ? lat + 10 : 4, fd, nd, nb);
        check($sformatf("op%0d done_lat", op), 64'(fd), 64'(lat));
        check($sformatf("op%0d n_done", op), 64'(nd), 64'(lat >= 0 ? 1 : 0));
        check($sformatf("op%0d busy_cyc", op), 64'(nb), 64'(runs ? lat : 0));
        check($sformatf("op%0d clk_pulses", op), 64'(pulses - p0), 64'(runs ? lat : 0));
        if (op == OP_CLEAR) exp_cnt = 64'd0;
        else if (runs) exp_cnt = new_trg;
        exp_trg = new_trg;
        check($sformatf("op%0d cnt", op), cnt_value, exp_cnt);
        check($sformatf("op%0d trg", op), gate_trg, exp_trg);
    endtask

    task automatic free_halt(input int n, input bit sat_load);
        int p0, nd, len;
        logic [63:0] at_halt;
        p0 = pulses;
        len = sat_load ? 1 : n;
        issue(OP_FREE, 32'd0);
        check("free trg", gate_trg, FV);
        check("free busy", 64'(busy), 64'd1);
        if (sat_load) begin
            preload_val = FV - 64'd3;
            preload_en  = 1'b1;
        end
        repeat (len - 1) tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        preload_en = 1'b0;
        at_halt = sat_load ? FV - 64'd3 : exp_cnt + 64'(len);
        check("halt done", 64'(done), 64'd1);
        check("halt busy", 64'(busy), 64'd0);
        check("halt trg", gate_trg, at_halt);
        check("halt cnt", cnt_value, at_halt);
        check("halt pulses", 64'(pulses - p0), 64'(len));
        nd = 0;
        repeat (3) begin
            tick();
            nd += int'(done);
        end
        check("halt extra done", 64'(nd), 64'd0);
        check("halt cnt frozen", cnt_value, at_halt);
        check("halt trg stable", gate_trg, at_halt);
        exp_cnt = at_halt;
        exp_trg = at_halt;
    endtask

    task automatic run_halt(input int arg, input int k);
        int p0, nd;
        p0 = pulses;
        issue(OP_RUN, 32'(arg));
        repeat (k - 1) tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("rh done", 64'(done), 64'd1);
        check("rh busy", 64'(busy), 64'd0);
        check("rh cnt", cnt_value, exp_cnt + 64'(k));
        check("rh trg", gate_trg, exp_cnt + 64'(k));
        nd = 0;
        repeat (3) begin
            tick();
            nd += int'(done);
        end
        check("rh extra done", 64'(nd), 64'd0);
        check("rh pulses", 64'(pulses - p0), 64'(k));
        exp_cnt = exp_cnt + 64'(k);
        exp_trg = exp_cnt;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nd;
        #1;
        check("rst gate_reset", 64'(gate_reset), 64'd1);
        tick();
        tick();
        check("rst gate_active", 64'(gate_active), 64'd0);
        check("rst gate_trg", gate_trg, 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst cmd_err", 64'(cmd_err), 64'd0);
        check("rst cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst gate_reset held", 64'(gate_reset), 64'd1);
        reset = 1'b0;
        tick();
        check("idle ready", 64'(cmd_ready), 64'd1);
        check("idle cnt", cnt_value, 64'd0);

        do_cmd(OP_STEP, 32'd0);
        do_cmd(OP_RUN, 32'd100);
        do_cmd(OP_RUN, 32'd50);
        do_cmd(OP_RUN, 32'd0);
        free_halt(37, 1'b0);
        do_cmd(OP_CLEAR, 32'd0);
        do_cmd(3'd6, 32'd0);

        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("idle halt done", 64'(done), 64'd0);
        check("idle halt trg", gate_trg, exp_trg);

        free_halt(1, 1'b1);
        do_cmd(OP_RUN, 32'd10);
        do_cmd(OP_CLEAR, 32'd0);

        for (int i = 0; i < 30; i++) begin
            int sel, a;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       do_cmd(OP_STEP, 32'd0);
                1, 2:    do_cmd(OP_RUN, 32'($urandom_range(0, 40)));
                3:       free_halt($urandom_range(1, 40), 1'b0);
                4:       do_cmd(OP_CLEAR, 32'd0);
                5:       do_cmd(3'($urandom_range(5, 7)), 32'd0);
                6:       do_cmd(OP_NOP, 32'd0);
                default: begin
                    a = $urandom_range(1, 30);
                    run_halt(a, $urandom_range(1, a));
                end
            endcase
        end

        issue(OP_RUN, 32'd30);
        repeat (5) tick();
        reset = 1'b1;
        #1;
        check("abort gate_active", 64'(gate_active), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort gate_reset", 64'(gate_reset), 64'd1);
        check("abort done", 64'(done), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        nd = 0;
        repeat (4) begin
            nd += int'(done);
            tick();
        end
        check("abort no done", 64'(nd), 64'd0);
        check("abort trg", gate_trg, 64'd0);
        check("abort cnt", cnt_value, 64'd0);
        check("abort ready", 64'(cmd_ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
